// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and default sizes for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_def_aw           = 8;
    localparam int c_def_dw           = 8;
    localparam int c_def_starve_limit = 4;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        LD_BURST = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_LD   = 2'd2
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_fsm
// Description : Arbitration state, optional loader starvation counter and
//               per-cycle grant decode. Starvation guard: DMEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = c_def_starve_limit
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       cpu_req,
    input  logic       ld_req,
    input  logic       ld_lock,
    output logic [1:0] grant
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    grant_e     w_grant;
    logic       w_starved;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt >= c_CNT_W'(STARVE_LIMIT));

    // Counts IDLE cycles where the loader asked but the CPU won
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant == GNT_LD) begin
            r_starve_cnt <= '0;
        end else if ((r_state == IDLE) && ld_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    // Strict CPU priority: the limit never takes effect
    assign w_starved = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = GNT_NONE;
        case (r_state)
            IDLE: begin
                if (ld_req && w_starved) begin
                    w_grant = GNT_LD;
                end else if (cpu_req) begin
                    w_grant = GNT_CPU;
                end else if (ld_req) begin
                    w_grant = GNT_LD;
                end
                if ((w_grant == GNT_LD) && ld_lock) begin
                    w_state_nxt = LD_BURST;
                end
            end
            LD_BURST: begin
                if (ld_req) begin
                    w_grant = GNT_LD;
                end
                if (!ld_req || !ld_lock) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // No grant at all while reset is asserted
        if (!Rst_n) begin
            w_grant = GNT_NONE;
        end
    end

    assign grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the CPU MEM stage
//               and the loader port. Optional guard: DMEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = c_def_aw,
    parameter int DW           = c_def_dw,
    parameter int STARVE_LIMIT = c_def_starve_limit
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_sp,
    input  logic [AW-1:0] cpu_addr,
    input  logic [AW-1:0] cpu_spv,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic          ld_lock,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ready,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_rvalid,
    output logic          mem_we,
    output logic          mem_wsp,
    output logic [AW-1:0] mem_sp,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    input  logic [DW-1:0] mem_x
);

    logic [1:0]    w_grant_raw;
    grant_e        w_grant;
    logic          w_cpu_gnt;
    logic          w_ld_gnt;
    logic          w_we;
    logic          w_wsp;
    logic [AW-1:0] w_mem_a;
    logic [AW-1:0] w_mem_sp;
    logic [DW-1:0] w_mem_wd;
    logic [AW-1:0] r_mem_a;
    logic [AW-1:0] r_mem_sp;
    logic [DW-1:0] r_mem_wd;
    logic [DW-1:0] r_cpu_rdata;
    logic          r_cpu_rvalid;
    logic [DW-1:0] r_ld_rdata;
    logic          r_ld_rvalid;

    dmem_arb_fsm #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fsm (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .cpu_req (cpu_req),
        .ld_req  (ld_req),
        .ld_lock (ld_lock),
        .grant   (w_grant_raw)
    );

    assign w_grant   = grant_e'(w_grant_raw);
    assign w_cpu_gnt = (w_grant == GNT_CPU);
    assign w_ld_gnt  = (w_grant == GNT_LD);

    // Address/data outputs keep their last value on cycles with no grant
    always_comb begin
        w_mem_a  = r_mem_a;
        w_mem_sp = r_mem_sp;
        w_mem_wd = r_mem_wd;
        w_we     = 1'b0;
        w_wsp    = 1'b0;
        if (w_cpu_gnt) begin
            w_mem_wd = cpu_wdata;
            if (cpu_sp) begin
                w_mem_sp = cpu_spv;
                w_wsp    = cpu_we;
            end else begin
                w_mem_a = cpu_addr;
                w_we    = cpu_we;
            end
        end else if (w_ld_gnt) begin
            w_mem_a  = ld_addr;
            w_mem_wd = ld_wdata;
            w_we     = ld_we;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mem_a      <= '0;
            r_mem_sp     <= '0;
            r_mem_wd     <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_ld_rdata   <= '0;
            r_ld_rvalid  <= 1'b0;
        end else begin
            r_mem_a      <= w_mem_a;
            r_mem_sp     <= w_mem_sp;
            r_mem_wd     <= w_mem_wd;
            r_cpu_rvalid <= w_cpu_gnt && !cpu_we;
            r_ld_rvalid  <= w_ld_gnt && !ld_we;
            if (w_cpu_gnt && !cpu_we) begin
                r_cpu_rdata <= cpu_sp ? mem_x : mem_rd;
            end
            if (w_ld_gnt && !ld_we) begin
                r_ld_rdata <= mem_rd;
            end
        end
    end

    // Write strobes are gated by reset directly so nothing lands mid-reset
    assign mem_we     = w_we && Rst_n;
    assign mem_wsp    = w_wsp && Rst_n;
    assign mem_a      = w_mem_a;
    assign mem_sp     = w_mem_sp;
    assign mem_wd     = w_mem_wd;
    assign cpu_ready  = w_cpu_gnt;
    assign ld_ready   = w_ld_gnt;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ld_rdata   = r_ld_rdata;
    assign ld_rvalid  = r_ld_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural model
//               and a data memory. Guard build: DMEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW           = 8;
    localparam int DW           = 8;
    localparam int STARVE_LIMIT = 4;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          cpu_req, cpu_we, cpu_sp;
    logic [AW-1:0] cpu_addr, cpu_spv;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ld_req, ld_we, ld_lock;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ready, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_we, mem_wsp;
    logic [AW-1:0] mem_sp, mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd, mem_x;

    dmem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_sp     (cpu_sp),
        .cpu_addr   (cpu_addr),
        .cpu_spv    (cpu_spv),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_lock    (ld_lock),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ready   (ld_ready),
        .ld_rdata   (ld_rdata),
        .ld_rvalid  (ld_rvalid),
        .mem_we     (mem_we),
        .mem_wsp    (mem_wsp),
        .mem_sp     (mem_sp),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .mem_x      (mem_x)
    );

    always #5 Clk = ~Clk;

    // Data memory: RD reads at A, X reads at Sp, both written on the rising edge
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    always @(posedge Clk) begin
        if (mem_we)  mem[mem_a]  <= mem_wd;
        if (mem_wsp) mem[mem_sp] <= mem_wd;
    end
    assign mem_rd = mem[mem_a];
    assign mem_x  = mem[mem_sp];

    // Reference model state
    logic [DW-1:0] sh [0:(1<<AW)-1] = '{default: '0};
    bit            m_burst;
    int            m_starve;
    bit            m_cpu_pend, m_ld_pend;
    logic [DW-1:0] m_cpu_rd, m_ld_rd;
    logic [AW-1:0] m_a, m_sp;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit gc, gl, starved, wr;
        logic [AW-1:0] ca;
        if (!Rst_n) begin
            chk("rst cpu_ready", 32'(cpu_ready), 32'(0));
            chk("rst ld_ready", 32'(ld_ready), 32'(0));
            chk("rst mem_we", 32'(mem_we), 32'(0));
            chk("rst mem_wsp", 32'(mem_wsp), 32'(0));
            chk("rst mem_a", 32'(mem_a), 32'(0));
            chk("rst mem_sp", 32'(mem_sp), 32'(0));
            chk("rst mem_wd", 32'(mem_wd), 32'(0));
            chk("rst rvalids", 32'({cpu_rvalid, ld_rvalid}), 32'(0));
            chk("rst rdatas", 32'({cpu_rdata, ld_rdata}), 32'(0));
            m_burst = 0; m_starve = 0; m_cpu_pend = 0; m_ld_pend = 0;
            m_cpu_rd = '0; m_ld_rd = '0; m_a = '0; m_sp = '0;
            return;
        end
        gc = 0; gl = 0; starved = 0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        starved = ld_req && (m_starve >= STARVE_LIMIT);
`endif
        if (m_burst)      gl = ld_req;
        else if (starved) gl = 1;
        else if (cpu_req) gc = 1;
        else if (ld_req)  gl = 1;

        ca = cpu_sp ? cpu_spv : cpu_addr;
        if (gc && !cpu_sp) m_a = cpu_addr;
        if (gc && cpu_sp)  m_sp = cpu_spv;
        if (gl)            m_a = ld_addr;
        wr = (gc && cpu_we) || (gl && ld_we);

        chk("cpu_ready", 32'(cpu_ready), 32'(gc));
        chk("ld_ready", 32'(ld_ready), 32'(gl));
        chk("mem_we", 32'(mem_we), 32'((gc && !cpu_sp && cpu_we) || (gl && ld_we)));
        chk("mem_wsp", 32'(mem_wsp), 32'(gc && cpu_sp && cpu_we));
        chk("mem_a", 32'(mem_a), 32'(m_a));
        chk("mem_sp", 32'(mem_sp), 32'(m_sp));
        if (wr) chk("mem_wd", 32'(mem_wd), 32'(gc ? cpu_wdata : ld_wdata));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_pend));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(m_ld_pend));
        chk("ld_rdata", 32'(ld_rdata), 32'(m_ld_rd));

        m_cpu_pend = gc && !cpu_we;
        if (m_cpu_pend) m_cpu_rd = sh[ca];
        m_ld_pend = gl && !ld_we;
        if (m_ld_pend) m_ld_rd = sh[ld_addr];
        if (gc && cpu_we) sh[ca] = cpu_wdata;
        if (gl && ld_we)  sh[ld_addr] = ld_wdata;
        if (gl) m_starve = 0;
        else if (!m_burst && ld_req) m_starve++;
        m_burst = m_burst ? (ld_req && ld_lock) : (gl && ld_lock);
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge Clk);
        model_check();
    endtask

    task automatic idle();
        cpu_req = 0; ld_req = 0; ld_lock = 0;
    endtask

    initial begin : main
        int  nc, nl, first_ld;
        bit  cpu_served, ld_served;
        cpu_req = 0; cpu_we = 0; cpu_sp = 0; cpu_addr = '0; cpu_spv = '0; cpu_wdata = '0;
        ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;
        adv();
        cyc(); adv();
        Rst_n = 1;

        // CPU data write then read back
        cpu_req = 1; cpu_we = 1; cpu_sp = 0; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        cyc();
        chk("wr cpu_ready", 32'(cpu_ready), 32'(1));
        chk("wr mem_a", 32'(mem_a), 32'h10);
        adv();
        cpu_we = 0;
        cyc();
        chk("rd cpu_ready", 32'(cpu_ready), 32'(1));
        adv();
        idle();
        cyc();
        chk("rd cpu_rvalid", 32'(cpu_rvalid), 32'(1));
        chk("rd cpu_rdata", 32'(cpu_rdata), 32'hA5);
        adv();

        // Stack push then stack read through X
        cpu_req = 1; cpu_we = 1; cpu_sp = 1; cpu_spv = 8'hFF; cpu_wdata = 8'h3C;
        cyc();
        chk("push mem_wsp", 32'(mem_wsp), 32'(1));
        chk("push mem_we", 32'(mem_we), 32'(0));
        chk("push mem_sp", 32'(mem_sp), 32'hFF);
        adv();
        cpu_we = 0;
        cyc(); adv();
        idle();
        cyc();
        chk("pop cpu_rdata", 32'(cpu_rdata), 32'h3C);
        adv();

        // Contention: both ports held for 10 cycles
        cpu_req = 1; cpu_we = 0; cpu_sp = 0; cpu_addr = 8'h01;
        ld_req = 1; ld_we = 0; ld_lock = 0; ld_addr = 8'h02;
        nc = 0; nl = 0; first_ld = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            nc += int'(cpu_ready);
            nl += int'(ld_ready);
            if (ld_ready && first_ld == 0) first_ld = i;
            adv();
        end
`ifdef DMEM_ARB_STARVE_GUARD_EN
        chk("contend cpu count", 32'(nc), 32'(8));
        chk("contend ld count", 32'(nl), 32'(2));
        chk("contend first ld", 32'(first_ld), 32'(5));
`else
        chk("contend cpu count", 32'(nc), 32'(10));
        chk("contend ld count", 32'(nl), 32'(0));
        chk("contend first ld", 32'(first_ld), 32'(0));
`endif
        cpu_req = 0;
        cyc();
        chk("drop cpu ld_ready", 32'(ld_ready), 32'(1));
        adv();
        idle();
        cyc(); adv();

        // Locked loader burst writing 0x00..0x07 while the CPU waits
        ld_req = 1; ld_we = 1;
        nc = 0; nl = 0;
        for (int i = 0; i < 8; i++) begin
            ld_addr = 8'(i); ld_wdata = 8'(8'h80 + i); ld_lock = (i != 7);
            cyc();
            nc += int'(cpu_ready);
            nl += int'(ld_ready);
            adv();
            if (i == 0) begin
                cpu_req = 1; cpu_we = 0; cpu_sp = 0; cpu_addr = 8'h03;
            end
        end
        chk("burst ld count", 32'(nl), 32'(8));
        chk("burst cpu count", 32'(nc), 32'(0));
        ld_req = 0; ld_lock = 0;
        cyc();
        chk("post burst cpu_ready", 32'(cpu_ready), 32'(1));
        adv();
        idle();
        ld_req = 1; ld_we = 0; ld_addr = 8'h05;
        cyc(); adv();
        idle();
        cyc();
        chk("ld readback", 32'(ld_rdata), 32'h85);
        adv();

        // Reset asserted mid-write with a read still in flight
        cpu_req = 1; cpu_we = 0; cpu_sp = 0; cpu_addr = 8'h10;
        cyc(); adv();
        cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h77;
        #1 Rst_n = 0;
        #1;
        chk("midrst mem_we", 32'(mem_we), 32'(0));
        chk("midrst cpu_ready", 32'(cpu_ready), 32'(0));
        chk("midrst cpu_rvalid", 32'(cpu_rvalid), 32'(0));
        cyc();
        idle();
        adv();
        cyc(); adv();
        Rst_n = 1;
        cpu_req = 1; cpu_we = 0; cpu_sp = 0; cpu_addr = 8'h20;
        cyc();
        chk("post rst rvalid", 32'(cpu_rvalid), 32'(0));
        adv();
        idle();
        cyc();
        chk("no write in reset", 32'(cpu_rdata), 32'h00);
        adv();

        // Randomised traffic honouring the hold-until-ready handshake
        cpu_served = 1; ld_served = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!cpu_req || cpu_served) begin
                cpu_req   = ($urandom % 100) < 60;
                cpu_we    = 1'($urandom);
                cpu_sp    = 1'($urandom);
                cpu_addr  = 8'($urandom_range(0, 15));
                cpu_spv   = 8'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (!ld_req || ld_served) begin
                ld_req   = ($urandom % 100) < 50;
                ld_we    = 1'($urandom);
                ld_lock  = ($urandom % 3) != 0;
                ld_addr  = 8'($urandom_range(0, 15));
                ld_wdata = 8'($urandom);
            end else if (($urandom % 8) == 0) begin
                ld_lock = 0;
            end
            cyc();
            cpu_served = cpu_ready;
            ld_served  = ld_ready;
            chk("one grant", 32'(cpu_ready && ld_ready), 32'(0));
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
